seq_mult_param: RTL

SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

---
 rtl/seq_mult_param_if.sv | 48 ++++
 rtl/seq_mult_param.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_mult_param_if.sv
// ----------------------------------------------------------------------------
// seq_mult_param_if
// Handshake/data bundle for the sequential shift-add multiplier.
//
// Signals (directions given from the multiplier's point of view, modport slave):
//   start_i   in   request to begin a multiplication (sampled only when idle)
//   signed_i  in   0 = unsigned, 1 = two's complement; captured with operands
//   a_bi      in   multiplicand, WIDTH bits
//   b_bi      in   multiplier, WIDTH bits
//   y_bo      out  product register, 2*WIDTH bits
//   busy_o    out  high while an operation is in progress
//   done_o    out  one-cycle pulse marking a new valid y_bo
// ----------------------------------------------------------------------------
interface seq_mult_param_if #(
  parameter int WIDTH = 8
);

  logic                   start_i;
  logic                   signed_i;
  logic [WIDTH-1:0]       a_bi;
  logic [WIDTH-1:0]       b_bi;
  logic [2*WIDTH-1:0]     y_bo;
  logic                   busy_o;
  logic                   done_o;

  // Requester side: drives the request and operands, observes the result.
  modport master (
    output start_i,
    output signed_i,
    output a_bi,
    output b_bi,
    input  y_bo,
    input  busy_o,
    input  done_o
  );

  // Multiplier side.
  modport slave (
    input  start_i,
    input  signed_i,
    input  a_bi,
    input  b_bi,
    output y_bo,
    output busy_o,
    output done_o
  );

endinterface

// File: rtl/seq_mult_param.sv
// ----------------------------------------------------------------------------
// seq_mult_param
// Sequential shift-add multiplier, one multiplier bit per clock.
// An operation accepted on edge k spends WIDTH edges in WORK, produces the
// product on the END edge k+WIDTH+1 and returns to IDLE, giving one result
// every WIDTH+2 cycles. Signed mode uses the two's complement identity
//   a*b = sum_{i<W-1} a*b[i]*2^i - a*b[W-1]*2^(W-1)
// with a sign-extended to 2*WIDTH, so the top partial product is subtracted.
//
// Ports:
//   clk_i    in   single clock, all state changes on the rising edge
//   rst_n_i  in   asynchronous active-low reset (release synchronised outside)
//   bus      --   seq_mult_param_if.slave: start_i, signed_i, a_bi, b_bi in;
//                 y_bo, busy_o, done_o out
// ----------------------------------------------------------------------------

// Protocol properties observed on the multiplier outputs.
module seq_mult_param_chk (
  input logic clk_i,
  input logic rst_n_i,
  input logic busy_i,
  input logic done_i
);

  // A completion is never reported while an operation is still running.
  a_done_not_busy: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) done_i |-> !busy_i
  );

  // done is a single-cycle pulse.
  a_done_pulse: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) done_i |=> !done_i
  );

endmodule

module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input logic           clk_i,
  input logic           rst_n_i,
  seq_mult_param_if.slave bus
);

  localparam int CTR_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WORK = 2'd1;
  localparam logic [1:0] ST_END  = 2'd2;

  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(WIDTH - 1);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_ZERO = CTR_W'(0);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic [PW-1:0]    r_acc;
  logic [CTR_W-1:0] r_ctr;
  logic [PW-1:0]    r_y;
  logic             r_busy;
  logic             r_done;

  logic [PW-1:0]    w_a_ext;
  logic             w_bit;
  logic [PW-1:0]    w_pp;
  logic             w_last;
  logic             w_sub;
  logic [PW-1:0]    w_acc_nxt;

  // Multiplicand widened to product width; sign extension makes the
  // modulo-2^(2W) accumulation exact for negative multiplicands.
  assign w_a_ext = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a}
                         : {{WIDTH{1'b0}}, r_a};

  // Partial product for the current multiplier bit, aligned to its weight.
  assign w_bit = r_b[r_ctr];
  assign w_pp  = (w_a_ext & {PW{w_bit}}) << r_ctr;

  // The MSB of a signed multiplier carries weight -2^(W-1): subtract it.
  assign w_last    = (r_ctr == CTR_LAST);
  assign w_sub     = r_sgn & w_last;
  assign w_acc_nxt = w_sub ? (r_acc - w_pp) : (r_acc + w_pp);

  // Control FSM, operand capture, accumulator and product register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_sgn   <= 1'b0;
      r_acc   <= {PW{1'b0}};
      r_ctr   <= CTR_ZERO;
      r_y     <= {PW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // done is only ever raised by the END edge, so it drops one cycle later.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_a     <= bus.a_bi;
            r_b     <= bus.b_bi;
            r_sgn   <= bus.signed_i;
            r_acc   <= {PW{1'b0}};
            r_ctr   <= CTR_ZERO;
            r_busy  <= 1'b1;
            r_state <= ST_WORK;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WORK: begin
          r_acc <= w_acc_nxt;
          if (w_last) begin
            r_state <= ST_END;
          end else begin
            r_ctr   <= r_ctr + CTR_ONE;
            r_state <= ST_WORK;
          end
        end
        ST_END: begin
          // start_i is not looked at here: a request during END is dropped
          // and a held request is taken on the following IDLE edge.
          r_y     <= r_acc;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y_bo   = r_y;
  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;

  seq_mult_param_chk u_chk (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .busy_i  (r_busy),
    .done_i  (r_done)
  );

endmodule
